// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and iteration count.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] value);
        return neg ? -value : value;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/done handshake between the datapath control and the multiply/divide unit.
interface muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    modport master (
        output start, op, src_a, src_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, op, src_a, src_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle over magnitudes, signs fixed up afterwards.
//   state  | meaning
//   IDLE   | waiting for start
//   CALC   | 32 shift-add / shift-subtract iterations, counter 31 -> 0
//   FIX    | sign correction and result select
//   DONE   | done pulse; a new start is accepted here
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    muldiv_if.slave bus
);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [63:0]        acc;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [2:0]         op_q;
    logic [4:0]         rd_q;
    logic               sa;
    logic               sb;
    logic               div_zero;

    logic               sign_a_in;
    logic               sign_b_in;
    logic [31:0]        mag_a_in;
    logic [31:0]        mag_b_in;
    logic               accept;

    logic [32:0]        mul_sum;
    logic [63:0]        mul_next;
    logic [32:0]        div_shift;
    logic               div_ge;
    logic [31:0]        div_rem;
    logic [63:0]        div_next;

    logic               neg_q;
    logic [63:0]        product;
    logic [31:0]        quotient;
    logic [31:0]        remainder;
    logic [31:0]        fix_result;

    always_comb begin
        sign_a_in = bus.src_a[31] && (bus.op == OP_MULH || bus.op == OP_MULHSU ||
                                      bus.op == OP_DIV  || bus.op == OP_REM);
        sign_b_in = bus.src_b[31] && (bus.op == OP_MULH || bus.op == OP_DIV ||
                                      bus.op == OP_REM);
        mag_a_in  = negate_if(sign_a_in, bus.src_a);
        mag_b_in  = negate_if(sign_b_in, bus.src_b);
        accept    = bus.start && (state == S_IDLE || state == S_DONE);
    end

    // acc holds {partial product, multiplier} for multiply and {partial remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};
        div_shift = acc[63:31];
        div_ge    = div_shift >= {1'b0, mag_b};
        div_rem   = div_ge ? 32'(div_shift - {1'b0, mag_b}) : div_shift[31:0];
        div_next  = {div_rem, acc[30:0], div_ge};
    end

    always_comb begin
        neg_q     = sa ^ sb;
        product   = neg_q ? -acc : acc;
        quotient  = div_zero ? 32'hFFFF_FFFF : negate_if(neg_q, acc[31:0]);
        // Divide by zero returns the original dividend, rebuilt from its magnitude and sign.
        remainder = div_zero ? negate_if(sa, mag_a) : negate_if(sa, acc[63:32]);
        case (op_q)
            OP_MUL:                       fix_result = product[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = product[63:32];
            OP_DIV, OP_DIVU:              fix_result = quotient;
            default:                      fix_result = remainder;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            acc        <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            sa         <= 1'b0;
            sb         <= 1'b0;
            div_zero   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.rd_out <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state    <= S_CALC;
                        count    <= CNT_W'(ITER - 1);
                        acc      <= {32'd0, bus.op[2] ? mag_a_in : mag_b_in};
                        mag_a    <= mag_a_in;
                        mag_b    <= mag_b_in;
                        op_q     <= bus.op;
                        rd_q     <= bus.rd_in;
                        sa       <= sign_a_in;
                        sb       <= sign_b_in;
                        div_zero <= bus.op[2] && (bus.src_b == 32'd0);
                        bus.busy <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc   <= op_q[2] ? div_next : mul_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    bus.result <= fix_result;
                    bus.rd_out <= rd_q;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b1;
                    state      <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the single-issue datapath. It consumes the two register-file read operands (RD1/RD2) and returns a 32-bit result with its destination index, in the form the register-file write port (A3/WD3/WE3) takes. It is a fixed-latency, start/done handshaked block. While it is busy, the control FSM stalls the rest of the datapath.

## Interface
- No parameters; data width fixed at 32.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request pulse; accepted only in IDLE or DONE.
- op  in  3  funct3 encoding of the operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (0–7).
- src_a  in  32  operand A, from RD1.
- src_b  in  32  operand B, from RD2.
- rd_in  in  5  destination register index.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse in DONE; drives the WE3 side.
- result  out  32  held from FIX until the next accepted start; drives the WD3 side.
- rd_out  out  5  latched rd_in; drives the A3 side.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE + start → CALC.
  - CALC runs for 32 iterations (counter 31→0); at count 0 → FIX.
  - FIX → DONE.
  - DONE + start → CALC.
  - DONE without start → IDLE.
- On accept, latch:
  - op and rd_in.
  - Operand signs sa and sb. sa is used for MULH, MULHSU, DIV, REM. sb is used for MULH, DIV, REM. Otherwise each sign is 0.
  - Magnitudes |a| and |b| as 32-bit unsigned values. |0x80000000| = 0x80000000.
  - Flag div_zero = (src_b == 0) for divide and remainder ops.
- Multiply: unsigned shift-add of the magnitudes into a 64-bit product, one bit per CALC cycle.
- Divide: restoring shift-subtract with a 33-bit partial remainder, one quotient bit per CALC cycle.
- FIX applies the sign correction:
  - Product is negated (64-bit) if sa^sb.
  - Quotient is negated if sa^sb.
  - Remainder is negated if sa.
- FIX selects the result:
  - MUL: product[31:0].
  - MULH, MULHSU, MULHU: product[63:32].
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- Division by zero, overriding the above:
  - Quotient = 0xFFFFFFFF.
  - Remainder = src_a, original value.
- Signed overflow (0x80000000 / 0xFFFFFFFF) needs no special case: the magnitude path gives quotient 0x80000000 and remainder 0.
- start in CALC or FIX is ignored, with no queueing and no effect on the operation in flight.
- Operands are sampled only at accept; later changes on src_a, src_b, rd_in and op have no effect.

## Timing
- Reset state: IDLE; busy=0, done=0, result=0, rd_out=0; internal accumulators and counter are 0.
- Accept edge = cycle 0.
  - busy is high from cycle 1 through cycle 33.
  - done is high only in cycle 34; result and rd_out are valid from cycle 34.
- Latency is the same for all ops, including divide by zero.
- Back-to-back:
  - start during DONE is accepted at that edge, giving a 34-cycle period.
  - busy rises in the following cycle.
  - result keeps its old value until the next FIX.
- Reset mid-operation (async):
  - Outputs immediately return to reset values.
  - done does not pulse for the aborted operation.
  - The first start after reset release starts a fresh operation.

## Structure
- Package muldiv_pkg holds:
  - Op localparams OP_MUL=3'b000 … OP_REMU=3'b111.
  - State encodings.
  - Constant ITER=32.
- No sub-module: a single shared counter and FSM; the multiply and divide datapaths share the operand and accumulator registers.

## Test plan
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB; MULH with the same operands → 0xFFFFFFFF; rd_out echoes rd_in=5.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD, REM → 0xFFFFFFFF; DIVU 7 / 2 → 3, REMU → 1.
- DIV 0xFFFFFFFB / 0 → 0xFFFFFFFF, REM → 0xFFFFFFFB; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- Start at cycle 0, then start pulses at cycles 5 and 20 with different operands:
  - done high only at cycle 34, with the first operation's result.
  - A start issued in DONE is accepted, and the next done pulse comes at cycle 68.
- Reset asserted between edges at cycle 10 of an operation:
  - busy, done and result drop to 0 at once.
  - No done pulse follows.
  - After release, a new MUL 3 × 4 completes with 12 after 34 cycles.
